// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern generator: shifts a latched pattern out MSB-first with a valid
// qualifier, with programmable repeat count and idle gaps, behind a start/busy/done handshake.
module seq_pattern_gen #(
  parameter int   MAX_LEN  = 16,
  parameter int   LEN_W    = $clog2(MAX_LEN) + 1,
  parameter int   REP_W    = 8,
  parameter int   GAP_W    = 4,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [REP_W-1:0]   repeat_cnt,
  input  logic [GAP_W-1:0]   gap,
  input  logic               abort,
  output logic               ser_out,
  output logic               ser_valid,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state_dbg
);

  // Handshake: start is a request sampled only in IDLE (busy=0); busy covers every
  // cycle from the first driven bit to the last; done pulses once in the cycle after
  // the final bit; abort ends a transfer without a done pulse.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t             state, state_d;
  logic [MAX_LEN-1:0] shreg, shreg_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   bit_cnt, bit_cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [REP_W-1:0]   rep_cnt, rep_cnt_d;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               done_d, ser_out_d, ser_valid_d, busy_d;
  logic [LEN_W-1:0]   len_eff;
  logic [MAX_LEN-1:0] pat_aligned;

  // Left-align the pattern so bit len-1 sits at the MSB and a plain left shift serialises it.
  assign len_eff     = (len > MAX_LEN_L) ? MAX_LEN_L : len;
  assign pat_aligned = pattern << (MAX_LEN_L - len_eff);
  assign state_dbg   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      pat_q     <= '0;
      bit_cnt   <= '0;
      len_q     <= '0;
      rep_cnt   <= '0;
      gap_cnt   <= '0;
      gap_q     <= '0;
      ser_out   <= IDLE_VAL;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      pat_q     <= pat_d;
      bit_cnt   <= bit_cnt_d;
      len_q     <= len_d;
      rep_cnt   <= rep_cnt_d;
      gap_cnt   <= gap_cnt_d;
      gap_q     <= gap_d;
      ser_out   <= ser_out_d;
      ser_valid <= ser_valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    pat_d     = pat_q;
    bit_cnt_d = bit_cnt;
    len_d     = len_q;
    rep_cnt_d = rep_cnt;
    gap_cnt_d = gap_cnt;
    gap_d     = gap_q;
    done_d    = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pat_d     = pat_aligned;
            len_d     = len_eff;
            gap_d     = gap;
            rep_cnt_d = (repeat_cnt == '0) ? REP_W'(1) : repeat_cnt;
            if (len_eff != '0) begin
              state_d   = ST_SEND;
              shreg_d   = pat_aligned;
              bit_cnt_d = len_eff;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (bit_cnt > LEN_W'(1)) begin
            shreg_d   = shreg << 1;
            bit_cnt_d = bit_cnt - LEN_W'(1);
          end else if (rep_cnt > REP_W'(1)) begin
            // Repetition counter only decrements while above 1, so it never wraps.
            rep_cnt_d = rep_cnt - REP_W'(1);
            if (gap_q != '0) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q;
            end else begin
              shreg_d   = pat_q;
              bit_cnt_d = len_q;
            end
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt > GAP_W'(1)) begin
            gap_cnt_d = gap_cnt - GAP_W'(1);
          end else begin
            state_d   = ST_SEND;
            shreg_d   = pat_q;
            bit_cnt_d = len_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from next-state values and registered alongside the state.
  always_comb begin
    ser_valid_d = (state_d == ST_SEND);
    ser_out_d   = ser_valid_d ? shreg_d[MAX_LEN-1] : IDLE_VAL;
    busy_d      = (state_d != ST_IDLE);
  end

endmodule
